mem_addr_reg: RTL and testbench
===============================

Name: mem_addr_reg

Overview:
- 16-bit memory address register that drives addr_in of the mem block, sitting directly upstream of it.
- Loaded bytewise from the 8-bit main bus, or whole from the 16-bit transfer bus.
- Supports post-access increment/decrement and signed 8-bit relative offset, so block copies and relative addressing need no extra bus cycles.
- Can assert either address byte back onto the main bus using the same active-low assert/enable scheme as the other bus-attached blocks.

Parameters:
- WIDTH_ADDR, 16, address width. Must be 2*WIDTH.
- WIDTH, 8, main bus width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- main_in  in  WIDTH  main bus data in.
- load_lo_n  in  1  active-low; load addr[7:0] from main_in.
- load_hi_n  in  1  active-low; load addr[15:8] from main_in.
- add_off_n  in  1  active-low; addr <= addr + sign-extended main_in.
- xfer_in  in  WIDTH_ADDR  16-bit transfer bus (from PC/SP).
- load_xfer_n  in  1  active-low; load full address from xfer_in.
- inc_n  in  1  active-low; addr <= addr + 1.
- dec_n  in  1  active-low; addr <= addr - 1.
- assert_lo_n  in  1  active-low; drive addr[7:0] onto main bus.
- assert_hi_n  in  1  active-low; drive addr[15:8] onto main bus.
- main_out  out  WIDTH  byte driven to main bus.
- main_en  out  1  high when main_out should drive the main bus.
- addr_out  out  WIDTH_ADDR  registered address, connects to mem addr_in.
- wrap  out  1  registered; high for one cycle after an update crossed FFFF<->0000.

Behaviour:
- Reset (rst high, any time, async): addr_out=0000, wrap=0. Takes effect immediately, mid-operation included. All controls are ignored while rst is high. The first update happens on the first rising edge after rst falls.
- One operation per rising edge, chosen by fixed priority:
  1. load_xfer_n
  2. load_hi_n / load_lo_n
  3. add_off_n
  4. inc_n / dec_n
  5. hold
- Lower-priority requests in the same cycle are dropped, not queued.
- load_hi_n and load_lo_n both low: both bytes take main_in (e.g. 3C -> 3C3C).
- inc_n and dec_n both low, with nothing of higher priority active: hold.
- Arithmetic is modulo 2^16.
  - add_off: main_in is treated as two's complement, range -128..+127.
- wrap: set to 1 on the edge where inc, dec or add_off crosses the boundary. Cases:
  - inc: FFFF -> 0000.
  - dec: 0000 -> FFFF.
  - add_off: unsigned carry out of bit 15 with a positive offset, or borrow with a negative offset.
- wrap: cleared to 0 on every other edge, including loads and hold.
- Latency: addr_out reflects an operation one edge after the control is sampled low. No combinational path exists from any control or data input to addr_out.
- Bus output (combinational from register state):
  - main_en = !assert_lo_n | !assert_hi_n.
  - main_out = addr[15:8] if assert_hi_n is low; else addr[7:0] if assert_lo_n is low; else 00.
  - Both asserts low: the high byte wins.
- Assert and load in the same cycle is legal. main_out shows the pre-edge value, and the register updates at the edge.
- addr_out is never tri-stated. mem sees the address continuously.

Decomposition:
- Shared package mem_addr_pkg contains:
  - WIDTH_ADDR and WIDTH defaults.
  - Enum addr_op_t {OP_HOLD, OP_XFER, OP_LOAD_BYTES, OP_ADD_OFF, OP_INC, OP_DEC}.
  - A priority-decode function mapping the active-low controls to addr_op_t.
- One natural sub-module: addr_alu. It is combinational: 16-bit input, op, 8-bit offset -> 16-bit result plus wrap. The register, priority decode and bus output stay in mem_addr_reg.

Test Plan:
- Reset: pulse rst between edges with addr at 1234 -> addr_out=0000 and wrap=0 before the next edge; controls held low during rst have no effect.
- Byte loads: main_in=80 with load_hi_n low, then main_in=00 with load_lo_n low -> addr_out=8000. assert_hi_n low -> main_en=1, main_out=80. Then assert_lo_n low with assert_hi_n high -> main_out=00.
- Increment and wrap: load_xfer to FFFE, then inc_n low for 3 edges -> FFFF, 0000, 0001. wrap=1 only after the edge producing 0000. Same check with dec_n from 0001 down to FFFF.
- Offset: addr=8010, main_in=F0, add_off_n low -> 8000, wrap=0. addr=FFF0, main_in=20 -> 0010, wrap=1.
- Priority: load_xfer_n, load_lo_n and inc_n all low with xfer_in=ABCD -> ABCD. inc_n and dec_n both low -> unchanged. load_hi_n and load_lo_n both low with main_in=3C -> 3C3C.
- Mem integration: drive addr_out into mem and write AA at 8000. inc, write 55 at 8001. dec, read back -> mem returns AA.

Source files
------------

// File: rtl/mem_addr_pkg.sv
// Shared widths, operation encoding and control priority decode for the
// memory address register and its ALU.
package mem_addr_pkg;

   localparam int WIDTH      = 8;
   localparam int WIDTH_ADDR = 16;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_XFER,
      OP_LOAD_BYTES,
      OP_ADD_OFF,
      OP_INC,
      OP_DEC
   } addr_op_t;

   // Fixed priority: transfer load, byte loads, offset add, inc/dec, hold.
   // Conflicting inc and dec cancel to a hold.
   function automatic addr_op_t decode_op(
      input logic load_xfer_n,
      input logic load_hi_n,
      input logic load_lo_n,
      input logic add_off_n,
      input logic inc_n,
      input logic dec_n
   );
      addr_op_t op;
      op = OP_HOLD;
      if (!load_xfer_n)
         op = OP_XFER;
      else if (!load_hi_n || !load_lo_n)
         op = OP_LOAD_BYTES;
      else if (!add_off_n)
         op = OP_ADD_OFF;
      else if (!inc_n && dec_n)
         op = OP_INC;
      else if (!dec_n && inc_n)
         op = OP_DEC;
      return op;
   endfunction

endpackage

// File: rtl/addr_alu.sv
// Combinational address arithmetic: increment, decrement and signed byte
// offset, with a flag for crossing the top/bottom of the address space.
module addr_alu
   import mem_addr_pkg::*;
#(
   parameter int WIDTH_ADDR = mem_addr_pkg::WIDTH_ADDR,
   parameter int WIDTH      = mem_addr_pkg::WIDTH
) (
   input  logic [WIDTH_ADDR-1:0] addr,
   input  addr_op_t              op,
   input  logic [WIDTH-1:0]      offset,
   output logic [WIDTH_ADDR-1:0] result,
   output logic                  wrap
);

   localparam logic [WIDTH_ADDR-1:0] ONE = {{(WIDTH_ADDR-1){1'b0}}, 1'b1};

   logic [WIDTH_ADDR-1:0] offset_ext;
   logic [WIDTH_ADDR:0]   sum;

   assign offset_ext = {{(WIDTH_ADDR-WIDTH){offset[WIDTH-1]}}, offset};
   assign sum        = {1'b0, addr} + {1'b0, offset_ext};

   always_comb begin
      // NOTE: defaults assigned first so every path drives both outputs; no latch is inferred.
      result = addr;
      wrap   = 1'b0;
      case (op)
         OP_ADD_OFF: begin
            result = sum[WIDTH_ADDR-1:0];
            // A negative offset wraps when the carry is absent (a borrow).
            wrap   = offset[WIDTH-1] ? !sum[WIDTH_ADDR] : sum[WIDTH_ADDR];
         end
         OP_INC: begin
            result = addr + ONE;
            wrap   = &addr;
         end
         OP_DEC: begin
            result = addr - ONE;
            wrap   = ~|addr;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_addr_reg.sv
// 16-bit memory address register: byte/transfer loads, inc/dec, signed
// offset, and active-low byte assert onto the 8-bit main bus.
module mem_addr_reg
   import mem_addr_pkg::*;
#(
   parameter int WIDTH_ADDR = mem_addr_pkg::WIDTH_ADDR,
   parameter int WIDTH      = mem_addr_pkg::WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      main_in,
   input  logic                  load_lo_n,
   input  logic                  load_hi_n,
   input  logic                  add_off_n,
   input  logic [WIDTH_ADDR-1:0] xfer_in,
   input  logic                  load_xfer_n,
   input  logic                  inc_n,
   input  logic                  dec_n,
   input  logic                  assert_lo_n,
   input  logic                  assert_hi_n,
   output logic [WIDTH-1:0]      main_out,
   output logic                  main_en,
   output logic [WIDTH_ADDR-1:0] addr_out,
   output logic                  wrap
);

   logic [WIDTH_ADDR-1:0] addr_q;
   logic [WIDTH_ADDR-1:0] alu_result;
   logic                  alu_wrap;
   addr_op_t              op;

   assign op = decode_op(load_xfer_n, load_hi_n, load_lo_n, add_off_n, inc_n, dec_n);

   addr_alu #(
      .WIDTH_ADDR (WIDTH_ADDR),
      .WIDTH      (WIDTH)
   ) u_alu (
      .addr   (addr_q),
      .op     (op),
      .offset (main_in),
      .result (alu_result),
      .wrap   (alu_wrap)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         wrap   <= 1'b0;
      end else begin
         // The ALU reports wrap only for arithmetic ops, so loads and hold clear it.
         wrap <= alu_wrap;
         case (op)
            OP_XFER: addr_q <= xfer_in;
            OP_LOAD_BYTES: begin
               if (!load_hi_n) addr_q[WIDTH_ADDR-1:WIDTH] <= main_in;
               if (!load_lo_n) addr_q[WIDTH-1:0]          <= main_in;
            end
            default: addr_q <= alu_result;
         endcase
      end
   end

   assign addr_out = addr_q;
   assign main_en  = !assert_lo_n || !assert_hi_n;

   always_comb begin
      main_out = '0;
      if (!assert_hi_n)
         main_out = addr_q[WIDTH_ADDR-1:WIDTH];
      else if (!assert_lo_n)
         main_out = addr_q[WIDTH-1:0];
   end

endmodule

// File: tb/tb_mem_addr_reg.sv
// Self-checking bench for mem_addr_reg: directed cases plus random stimulus
// against an integer-arithmetic reference model and a small memory model.
module tb_mem_addr_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  main_in;
   logic        load_lo_n, load_hi_n, add_off_n, load_xfer_n, inc_n, dec_n;
   logic        assert_lo_n, assert_hi_n;
   logic [15:0] xfer_in;
   logic [7:0]  main_out;
   logic        main_en;
   logic [15:0] addr_out;
   logic        wrap;

   int checks = 0;
   int errors = 0;

   // Reference state
   int m_addr = 0;
   bit m_wrap = 1'b0;

   // Memory model fed by addr_out
   logic [7:0] mem [int];
   logic       mem_we = 1'b0;
   logic [7:0] mem_wdata = 8'h00;

   mem_addr_reg dut (
      .clk         (clk),
      .rst         (rst),
      .main_in     (main_in),
      .load_lo_n   (load_lo_n),
      .load_hi_n   (load_hi_n),
      .add_off_n   (add_off_n),
      .xfer_in     (xfer_in),
      .load_xfer_n (load_xfer_n),
      .inc_n       (inc_n),
      .dec_n       (dec_n),
      .assert_lo_n (assert_lo_n),
      .assert_hi_n (assert_hi_n),
      .main_out    (main_out),
      .main_en     (main_en),
      .addr_out    (addr_out),
      .wrap        (wrap)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[int'(addr_out)] = mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_idle();
      load_lo_n   = 1'b1;
      load_hi_n   = 1'b1;
      add_off_n   = 1'b1;
      load_xfer_n = 1'b1;
      inc_n       = 1'b1;
      dec_n       = 1'b1;
      assert_lo_n = 1'b1;
      assert_hi_n = 1'b1;
      mem_we      = 1'b0;
   endtask

   // Next address computed from the rules with plain integer arithmetic.
   task automatic model_step();
      int n;
      int off;
      n = m_addr;
      m_wrap = 1'b0;
      if (!load_xfer_n) begin
         n = int'(xfer_in);
      end else if (!load_hi_n || !load_lo_n) begin
         if (!load_hi_n) n = (n % 256) + int'(main_in) * 256;
         if (!load_lo_n) n = (n / 256) * 256 + int'(main_in);
      end else if (!add_off_n) begin
         off = (main_in >= 8'd128) ? int'(main_in) - 256 : int'(main_in);
         n = m_addr + off;
      end else if (!inc_n && dec_n) begin
         n = m_addr + 1;
      end else if (!dec_n && inc_n) begin
         n = m_addr - 1;
      end
      if (n < 0 || n > 65535) m_wrap = 1'b1;
      m_addr = ((n % 65536) + 65536) % 65536;
   endtask

   task automatic bus_check(input string tag);
      int exp_out;
      exp_out = 0;
      if (!assert_hi_n)      exp_out = m_addr / 256;
      else if (!assert_lo_n) exp_out = m_addr % 256;
      check({tag, "_en"}, 32'(main_en), 32'(!assert_lo_n || !assert_hi_n));
      check({tag, "_out"}, 32'(main_out), 32'(exp_out));
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check({tag, "_addr"}, 32'(addr_out), 32'(m_addr));
      check({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
   endtask

   task automatic xfer(input logic [15:0] value);
      set_idle();
      load_xfer_n = 1'b0;
      xfer_in     = value;
      tick("xfer");
      set_idle();
   endtask

   initial begin
      set_idle();
      main_in = 8'h00;
      xfer_in = 16'h0000;
      rst     = 1'b1;
      #1;
      check("reset_addr", 32'(addr_out), 32'h0000);
      check("reset_wrap", 32'(wrap), 32'h0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Byte loads and bus assert
      load_hi_n = 1'b0; main_in = 8'h80; tick("load_hi"); set_idle();
      load_lo_n = 1'b0; main_in = 8'h00; tick("load_lo"); set_idle();
      check("byte_load_8000", 32'(addr_out), 32'h8000);
      assert_hi_n = 1'b0; #1;
      check("assert_hi_en", 32'(main_en), 32'h1);
      check("assert_hi_out", 32'(main_out), 32'h80);
      assert_lo_n = 1'b0; #1;
      check("assert_both_hi_wins", 32'(main_out), 32'h80);
      assert_hi_n = 1'b1; #1;
      check("assert_lo_out", 32'(main_out), 32'h00);
      check("assert_lo_en", 32'(main_en), 32'h1);
      set_idle(); #1;
      check("no_assert_en", 32'(main_en), 32'h0);

      // Assert and load together: bus shows pre-edge value
      assert_lo_n = 1'b0; load_lo_n = 1'b0; main_in = 8'h77; #1;
      check("assert_preload", 32'(main_out), 32'h00);
      tick("assert_load");
      check("assert_postload", 32'(main_out), 32'h77);
      set_idle();

      // Increment across FFFF
      xfer(16'hFFFE);
      inc_n = 1'b0;
      tick("inc1"); check("inc_ffff", 32'(addr_out), 32'hFFFF); check("inc_ffff_wrap", 32'(wrap), 32'h0);
      tick("inc2"); check("inc_0000", 32'(addr_out), 32'h0000); check("inc_0000_wrap", 32'(wrap), 32'h1);
      tick("inc3"); check("inc_0001", 32'(addr_out), 32'h0001); check("inc_0001_wrap", 32'(wrap), 32'h0);
      set_idle();

      // Decrement across 0000
      dec_n = 1'b0;
      tick("dec1"); check("dec_0000_wrap", 32'(wrap), 32'h0);
      tick("dec2"); check("dec_ffff", 32'(addr_out), 32'hFFFF); check("dec_ffff_wrap", 32'(wrap), 32'h1);
      set_idle();
      tick("hold_clears_wrap"); check("hold_wrap", 32'(wrap), 32'h0);

      // Signed offset
      xfer(16'h8010);
      add_off_n = 1'b0; main_in = 8'hF0; tick("off_neg");
      check("off_8000", 32'(addr_out), 32'h8000); check("off_8000_wrap", 32'(wrap), 32'h0);
      set_idle();
      xfer(16'hFFF0);
      add_off_n = 1'b0; main_in = 8'h20; tick("off_pos");
      check("off_0010", 32'(addr_out), 32'h0010); check("off_0010_wrap", 32'(wrap), 32'h1);
      set_idle();

      // Priority
      load_xfer_n = 1'b0; load_lo_n = 1'b0; inc_n = 1'b0; xfer_in = 16'hABCD; main_in = 8'h11;
      tick("prio_xfer"); check("prio_abcd", 32'(addr_out), 32'hABCD);
      set_idle();
      inc_n = 1'b0; dec_n = 1'b0; tick("inc_dec_hold"); check("inc_dec_abcd", 32'(addr_out), 32'hABCD);
      set_idle();
      load_hi_n = 1'b0; load_lo_n = 1'b0; main_in = 8'h3C; tick("both_bytes");
      check("both_3c3c", 32'(addr_out), 32'h3C3C);
      set_idle();

      // Asynchronous reset between edges, controls ignored while high
      xfer(16'h1234);
      #2;
      rst = 1'b1;
      #1;
      m_addr = 0; m_wrap = 1'b0;
      check("midreset_addr", 32'(addr_out), 32'h0000);
      check("midreset_wrap", 32'(wrap), 32'h0);
      load_xfer_n = 1'b0; inc_n = 1'b0; xfer_in = 16'hFFFF;
      @(posedge clk);
      #1;
      check("reset_ignores_ctrl", 32'(addr_out), 32'h0000);
      #2;
      rst = 1'b0;
      load_xfer_n = 1'b1;
      tick("first_after_reset");
      check("first_after_reset_0001", 32'(addr_out), 32'h0001);
      set_idle();

      // Random stimulus against the model
      for (int i = 0; i < 400; i++) begin
         main_in     = 8'($urandom);
         load_xfer_n = ($urandom_range(0, 7) != 0);
         load_hi_n   = ($urandom_range(0, 5) != 0);
         load_lo_n   = ($urandom_range(0, 5) != 0);
         add_off_n   = ($urandom_range(0, 3) != 0);
         inc_n       = ($urandom_range(0, 2) != 0);
         dec_n       = ($urandom_range(0, 2) != 0);
         assert_lo_n = ($urandom_range(0, 1) != 0);
         assert_hi_n = ($urandom_range(0, 1) != 0);
         case ($urandom_range(0, 4))
            0: xfer_in = 16'hFFFF;
            1: xfer_in = 16'h0000;
            2: xfer_in = 16'hFFF0;
            3: xfer_in = 16'h0010;
            default: xfer_in = 16'($urandom);
         endcase
         #1;
         bus_check("rnd_bus");
         tick("rnd");
      end
      set_idle();

      // Memory integration through addr_out
      xfer(16'h8000);
      mem_we = 1'b1; mem_wdata = 8'hAA; tick("mem_wr_aa"); set_idle();
      inc_n = 1'b0; tick("mem_inc"); set_idle();
      mem_we = 1'b1; mem_wdata = 8'h55; tick("mem_wr_55"); set_idle();
      dec_n = 1'b0; tick("mem_dec"); set_idle();
      check("mem_addr_8000", 32'(addr_out), 32'h8000);
      check("mem_read_aa", 32'(mem.exists(int'(addr_out)) ? mem[int'(addr_out)] : 8'hXX), 32'hAA);
      check("mem_read_55", 32'(mem.exists(32'h8001) ? mem[32'h8001] : 8'hXX), 32'h55);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
